// File: rtl/sc_level_sequencer.sv
// Frogger-style level sequencer: start/restart handshake, lives bookkeeping,
// level-advance request pulse and win flag, all driven by edge-detected inputs.
module sc_level_sequencer #(
    parameter int CURRENTSTATE_DATAWIDTH = 2,
    parameter int LEVELCOUNTER_DATAWIDTH = 3,
    parameter int LIVES_DATAWIDTH        = 2,
    parameter int INITIAL_LIVES          = 3,
    parameter int MAX_LEVEL              = 5
) (
    input  logic                              SC_LEVEL_SEQUENCER_CLOCK_50,
    input  logic                              SC_LEVEL_SEQUENCER_RESET_InHigh,
    input  logic                              SC_LEVEL_SEQUENCER_Start_InLow,
    input  logic                              SC_LEVEL_SEQUENCER_Goal_InHigh,
    input  logic                              SC_LEVEL_SEQUENCER_Collision_InHigh,
    input  logic [LEVELCOUNTER_DATAWIDTH-1:0] SC_LEVEL_SEQUENCER_Level_InBus,
    output logic [CURRENTSTATE_DATAWIDTH-1:0] SC_LEVEL_SEQUENCER_CurrentState_OutBus,
    output logic                              SC_LEVEL_SEQUENCER_CountSignal_OutLow,
    output logic [LIVES_DATAWIDTH-1:0]        SC_LEVEL_SEQUENCER_Lives_OutBus,
    output logic                              SC_LEVEL_SEQUENCER_Win_OutHigh
);

    localparam logic [1:0] AWAITSTART_0 = 2'd0;
    localparam logic [1:0] STARTGAME_0  = 2'd1;
    localparam logic [1:0] ENDGAME_0    = 2'd2;
    localparam logic [1:0] AWAITSTART_1 = 2'd3;

    localparam logic [LIVES_DATAWIDTH-1:0]        LIVES_INIT = LIVES_DATAWIDTH'(INITIAL_LIVES);
    localparam logic [LIVES_DATAWIDTH-1:0]        LIVES_ONE  = LIVES_DATAWIDTH'(1);
    localparam logic [LEVELCOUNTER_DATAWIDTH-1:0] LEVEL_MAX  = LEVELCOUNTER_DATAWIDTH'(MAX_LEVEL);

    logic [1:0]                 state_q, state_d;
    logic [LIVES_DATAWIDTH-1:0] lives_q, lives_d;
    logic                       win_q, win_d;
    logic                       count_n_q, count_n_d;
    logic                       start_prev_q, goal_prev_q, coll_prev_q;
    logic                       post_reset_q;

    logic start_ev, goal_ev, coll_ev;

    // The edge registers reset to their inactive levels, so the first cycle after
    // reset is masked; an input held active through reset must drop and re-assert.
    assign start_ev = ~post_reset_q & start_prev_q & ~SC_LEVEL_SEQUENCER_Start_InLow;
    assign goal_ev  = ~post_reset_q & ~goal_prev_q & SC_LEVEL_SEQUENCER_Goal_InHigh;
    assign coll_ev  = ~post_reset_q & ~coll_prev_q & SC_LEVEL_SEQUENCER_Collision_InHigh;

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        win_d     = win_q;
        count_n_d = 1'b1;
        case (state_q)
            AWAITSTART_0: begin
                if (start_ev) state_d = AWAITSTART_1;
            end
            AWAITSTART_1: begin
                state_d = STARTGAME_0;
            end
            STARTGAME_0: begin
                // Collision wins over a simultaneous goal.
                if (coll_ev) begin
                    if (lives_q > LIVES_ONE) begin
                        lives_d = lives_q - LIVES_ONE;
                    end else begin
                        lives_d = '0;
                        win_d   = 1'b0;
                        state_d = ENDGAME_0;
                    end
                end else if (goal_ev) begin
                    if (SC_LEVEL_SEQUENCER_Level_InBus < LEVEL_MAX) begin
                        count_n_d = 1'b0;
                    end else begin
                        win_d   = 1'b1;
                        state_d = ENDGAME_0;
                    end
                end
            end
            default: begin
                if (start_ev) begin
                    state_d = AWAITSTART_0;
                    lives_d = LIVES_INIT;
                    win_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge SC_LEVEL_SEQUENCER_CLOCK_50) begin
        if (SC_LEVEL_SEQUENCER_RESET_InHigh) begin
            state_q      <= AWAITSTART_0;
            lives_q      <= LIVES_INIT;
            win_q        <= 1'b0;
            count_n_q    <= 1'b1;
            start_prev_q <= 1'b1;
            goal_prev_q  <= 1'b0;
            coll_prev_q  <= 1'b0;
            post_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            win_q        <= win_d;
            count_n_q    <= count_n_d;
            start_prev_q <= SC_LEVEL_SEQUENCER_Start_InLow;
            goal_prev_q  <= SC_LEVEL_SEQUENCER_Goal_InHigh;
            coll_prev_q  <= SC_LEVEL_SEQUENCER_Collision_InHigh;
            post_reset_q <= 1'b0;
        end
    end

    assign SC_LEVEL_SEQUENCER_CurrentState_OutBus = CURRENTSTATE_DATAWIDTH'(state_q);
    assign SC_LEVEL_SEQUENCER_CountSignal_OutLow  = count_n_q;
    assign SC_LEVEL_SEQUENCER_Lives_OutBus        = lives_q;
    assign SC_LEVEL_SEQUENCER_Win_OutHigh         = win_q;

endmodule

// File: tb/tb_sc_level_sequencer.sv
// Scoreboard bench for sc_level_sequencer: directed game scenarios followed by
// randomized play, each cycle's expected outputs queued from a reference model.
module tb_sc_level_sequencer;

    localparam int INIT_LIVES = 3;
    localparam int MAXLVL     = 5;

    // Game phases as reported on the state bus.
    localparam int PH_WAIT  = 0;
    localparam int PH_PLAY  = 1;
    localparam int PH_OVER  = 2;
    localparam int PH_ARMED = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_n = 1'b1;
    logic       goal = 1'b0;
    logic       coll = 1'b0;
    logic [2:0] level = '0;
    logic [1:0] state_o;
    logic       count_n_o;
    logic [1:0] lives_o;
    logic       win_o;

    sc_level_sequencer #(
        .CURRENTSTATE_DATAWIDTH(2),
        .LEVELCOUNTER_DATAWIDTH(3),
        .LIVES_DATAWIDTH(2),
        .INITIAL_LIVES(INIT_LIVES),
        .MAX_LEVEL(MAXLVL)
    ) dut (
        .SC_LEVEL_SEQUENCER_CLOCK_50(clk),
        .SC_LEVEL_SEQUENCER_RESET_InHigh(rst),
        .SC_LEVEL_SEQUENCER_Start_InLow(start_n),
        .SC_LEVEL_SEQUENCER_Goal_InHigh(goal),
        .SC_LEVEL_SEQUENCER_Collision_InHigh(coll),
        .SC_LEVEL_SEQUENCER_Level_InBus(level),
        .SC_LEVEL_SEQUENCER_CurrentState_OutBus(state_o),
        .SC_LEVEL_SEQUENCER_CountSignal_OutLow(count_n_o),
        .SC_LEVEL_SEQUENCER_Lives_OutBus(lives_o),
        .SC_LEVEL_SEQUENCER_Win_OutHigh(win_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int phase;
        int count_n;
        int lives;
        int win;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   driving_done = 1'b0;

    // Reference model: game phase, lives as an integer, and last-seen input levels.
    int m_phase = PH_WAIT;
    int m_lives = INIT_LIVES;
    int m_win = 0;
    int m_cnt = 1;
    bit m_prev_start_n = 1'b1;
    bit m_prev_goal = 1'b0;
    bit m_prev_coll = 1'b0;
    bit m_prev_was_reset = 1'b1;

    task automatic model_step(input bit r, input bit s_n, input bit g, input bit c, input int lvl);
        bit start_evt, goal_evt, coll_evt;
        if (r) begin
            m_phase = PH_WAIT;
            m_lives = INIT_LIVES;
            m_win = 0;
            m_cnt = 1;
            m_prev_was_reset = 1'b1;
        end else begin
            // A press only counts if the input was seen inactive on a non-reset edge.
            start_evt = !m_prev_was_reset && m_prev_start_n && !s_n;
            goal_evt  = !m_prev_was_reset && !m_prev_goal && g;
            coll_evt  = !m_prev_was_reset && !m_prev_coll && c;
            m_cnt = 1;
            if (m_phase == PH_WAIT) begin
                if (start_evt) m_phase = PH_ARMED;
            end else if (m_phase == PH_ARMED) begin
                m_phase = PH_PLAY;
            end else if (m_phase == PH_PLAY) begin
                if (coll_evt) begin
                    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                    if (m_lives == 0) begin
                        m_win = 0;
                        m_phase = PH_OVER;
                    end
                end else if (goal_evt) begin
                    if (lvl < MAXLVL) m_cnt = 0;
                    else begin
                        m_win = 1;
                        m_phase = PH_OVER;
                    end
                end
            end else begin
                if (start_evt) begin
                    m_phase = PH_WAIT;
                    m_lives = INIT_LIVES;
                    m_win = 0;
                end
            end
            m_prev_was_reset = 1'b0;
        end
        m_prev_start_n = s_n;
        m_prev_goal = g;
        m_prev_coll = c;
    endtask

    task automatic cyc(input bit r, input bit s_n, input bit g, input bit c, input int lvl);
        exp_t e;
        rst = r;
        start_n = s_n;
        goal = g;
        coll = c;
        level = 3'(lvl);
        model_step(r, s_n, g, c, lvl);
        e.phase = m_phase;
        e.count_n = m_cnt;
        e.lives = m_lives;
        e.win = m_win;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input int lvl);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, lvl);
    endtask

    // Monitor: one expected record per active edge, compared 2 time units after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 4;
                if (int'(state_o) !== e.phase) begin
                    errors++;
                    $display("FAIL state: got %0d expected %0d at %0t", state_o, e.phase, $time);
                end
                if (int'(count_n_o) !== e.count_n) begin
                    errors++;
                    $display("FAIL count_n: got %0d expected %0d at %0t", count_n_o, e.count_n, $time);
                end
                if (int'(lives_o) !== e.lives) begin
                    errors++;
                    $display("FAIL lives: got %0d expected %0d at %0t", lives_o, e.lives, $time);
                end
                if (int'(win_o) !== e.win) begin
                    errors++;
                    $display("FAIL win: got %0d expected %0d at %0t", win_o, e.win, $time);
                end
            end
        end
    end

    initial begin
        bit s_n, g, c, r;
        int lvl;

        // Reset, then a single start press walks through the arming state.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        idle(2, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(3, 2);

        // Held goal at level 2 gives one request pulse.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 2);
        idle(2, 2);

        // Three hits end the game; a fourth is ignored.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b1, 2);
            idle(1, 2);
        end

        // Restart, play, then clear the final level.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(1, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(3, 5);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 5);
        idle(2, 5);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5);
        idle(2, 0);

        // Simultaneous goal and hit: hit wins, twice.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(3, 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1);
        idle(1, 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1);
        idle(1, 1);

        // Reset lands on the request-pulse cycle.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1);
        idle(2, 1);

        // Start held low through reset release must not arm.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(3, 0);

        // Randomized play with held levels and occasional resets.
        s_n = 1'b1;
        g = 1'b0;
        c = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) < 2);
            if (s_n) s_n = ($urandom_range(0, 99) >= 10);
            else     s_n = ($urandom_range(0, 99) < 50);
            if (!g)  g = ($urandom_range(0, 99) < 12);
            else     g = ($urandom_range(0, 99) >= 40);
            if (!c)  c = ($urandom_range(0, 99) < 8);
            else     c = ($urandom_range(0, 99) >= 40);
            lvl = ($urandom_range(0, 3) == 0) ? MAXLVL + $urandom_range(0, 2) : $urandom_range(0, MAXLVL);
            cyc(r, s_n, g, c, lvl);
        end
        idle(3, 0);
        driving_done = 1'b1;
    end

    initial begin
        fork
            wait (driving_done);
            #400000;
        join_any
        disable fork;
        if (!driving_done) begin
            errors++;
            $display("FAIL timeout: got stalled stimulus expected completion at %0t", $time);
        end
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
